// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for the microcoded CPU datapath. Holds the PC and
// updates it once per rising clock edge from the 32-bit microcode control
// word. The supported operations are increment, absolute load, PC-relative
// branch, and call/return through an internal return-address stack. The unit
// also provides registered copies of the PC for the MBR and the MAR.
//
// Parameters
//   ADDR_W       PC / address width in bits                (default 8)
//   STACK_DEPTH  return-address stack entries, >= 2        (default 4)
//   INC_STEP     increment amount, also the return offset  (default 1)
//
// Ports
//   clk             in   1       system clock, rising edge
//   rst             in   1       asynchronous reset, active low
//   control_signal  in   32      microcode control word
//                                  [1]  PC->MBR      [2]  PC->MAR
//                                  [3]  MBR->PC      [20] increment
//                                  [21] branch       [22] call
//                                  [23] return       (other bits ignored)
//   data_from_mbr   in   ADDR_W  load / call target, or signed branch offset
//   data_to_mbr     out  ADDR_W  PC copy for the MBR (registered)
//   data_to_mar     out  ADDR_W  PC copy for the MAR (registered)
//   pc_out          out  ADDR_W  current PC
//   stack_full      out  1       stack holds STACK_DEPTH entries
//   stack_empty     out  1       stack holds no entries
//   stack_err       out  1       sticky overflow/underflow/conflict flag
//
// Configuration macro
//   PC_STACK_WRAP_EN
//     defined   - a call on a full stack overwrites the oldest entry
//                 (circular). The stack depth stays at STACK_DEPTH, the PC
//                 jumps as usual, and stack_err is unaffected.
//     undefined - a call on a full stack is rejected. The PC and the stack
//                 hold, and stack_err is set.
// ---------------------------------------------------------------------------
module pc_stack_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int INC_STEP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       control_signal,
  input  logic [ADDR_W-1:0] data_from_mbr,
  output logic [ADDR_W-1:0] data_to_mbr,
  output logic [ADDR_W-1:0] data_to_mar,
  output logic [ADDR_W-1:0] pc_out,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  // The stack depth counter must be able to hold the value STACK_DEPTH, so it
  // needs one more state than the entry pointer.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  localparam logic [SP_W-1:0]   SP_ZERO  = '0;
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0]   SP_MAX   = SP_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO = '0;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(STACK_DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INC_STEP);

  // Control word bit positions.
  localparam int BIT_TO_MBR = 1;
  localparam int BIT_TO_MAR = 2;
  localparam int BIT_LOAD   = 3;
  localparam int BIT_INC    = 20;
  localparam int BIT_BRANCH = 21;
  localparam int BIT_CALL   = 22;
  localparam int BIT_RET    = 23;

  // Decoded PC operation for this edge. The error cases get their own codes
  // so that the next-state logic becomes a flat case statement.
  localparam logic [3:0] OP_HOLD      = 4'd0;
  localparam logic [3:0] OP_INC       = 4'd1;
  localparam logic [3:0] OP_BRANCH    = 4'd2;
  localparam logic [3:0] OP_LOAD      = 4'd3;
  localparam logic [3:0] OP_CALL      = 4'd4;
  localparam logic [3:0] OP_CALL_FULL = 4'd5;
  localparam logic [3:0] OP_RET       = 4'd6;
  localparam logic [3:0] OP_RET_EMPTY = 4'd7;
  localparam logic [3:0] OP_CONFLICT  = 4'd8;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;        // number of valid entries, 0..STACK_DEPTH
  logic [PTR_W-1:0]  wr_ptr;    // next slot to write; oldest slot when full
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  logic do_to_mbr;
  logic do_to_mar;
  logic do_load;
  logic do_inc;
  logic do_branch;
  logic do_call;
  logic do_ret;

  assign do_to_mbr = control_signal[BIT_TO_MBR];
  assign do_to_mar = control_signal[BIT_TO_MAR];
  assign do_load   = control_signal[BIT_LOAD];
  assign do_inc    = control_signal[BIT_INC];
  assign do_branch = control_signal[BIT_BRANCH];
  assign do_call   = control_signal[BIT_CALL];
  assign do_ret    = control_signal[BIT_RET];

  // The remaining control bits belong to other datapath blocks.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{control_signal[31:24], control_signal[19:4],
                              control_signal[0]};

  // -------------------------------------------------------------------------
  // Stack flags and pointer arithmetic
  // -------------------------------------------------------------------------
  assign stack_empty = (sp == SP_ZERO);
  assign stack_full  = (sp == SP_MAX);

  // The pointers wrap explicitly so that STACK_DEPTH does not have to be a
  // power of two.
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_inc;

  assign top_ptr = (wr_ptr == PTR_ZERO) ? PTR_LAST : (wr_ptr - PTR_ONE);
  assign ptr_inc = (wr_ptr == PTR_LAST) ? PTR_ZERO : (wr_ptr + PTR_ONE);

  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] stack_top;

  assign ret_addr  = pc + STEP;
  assign stack_top = stack_mem[top_ptr];

  // -------------------------------------------------------------------------
  // Priority decode: return > call > load > branch > increment
  // -------------------------------------------------------------------------
  logic [3:0] op;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first. Without the default, a missed branch infers a latch.
    op = OP_HOLD;
    if (do_ret && do_call) begin
      op = OP_CONFLICT;
    end else if (do_ret) begin
      op = stack_empty ? OP_RET_EMPTY : OP_RET;
    end else if (do_call) begin
`ifdef PC_STACK_WRAP_EN
      op = OP_CALL;
`else
      op = stack_full ? OP_CALL_FULL : OP_CALL;
`endif
    end else if (do_load) begin
      op = OP_LOAD;
    end else if (do_branch) begin
      op = OP_BRANCH;
    end else if (do_inc) begin
      op = OP_INC;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_next;
  logic [SP_W-1:0]   sp_next;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic              push_en;
  logic              err_set;

  always_comb begin
    pc_next     = pc;
    sp_next     = sp;
    wr_ptr_next = wr_ptr;
    push_en     = 1'b0;
    err_set     = 1'b0;

    case (op)
      OP_INC: begin
        pc_next = pc + STEP;
      end

      // The offset is as wide as the PC. Adding it modulo 2^ADDR_W therefore
      // gives the same result as adding its sign-extended value.
      OP_BRANCH: begin
        pc_next = pc + data_from_mbr;
      end

      OP_LOAD: begin
        pc_next = data_from_mbr;
      end

      // On a full stack (only reachable with wrap enabled), wr_ptr points at
      // the oldest entry. That entry is overwritten and the depth saturates.
      OP_CALL: begin
        push_en     = 1'b1;
        pc_next     = data_from_mbr;
        wr_ptr_next = ptr_inc;
        if (!stack_full) begin
          sp_next = sp + SP_ONE;
        end
      end

      OP_RET: begin
        pc_next     = stack_top;
        sp_next     = sp - SP_ONE;
        wr_ptr_next = top_ptr;
      end

      OP_CALL_FULL,
      OP_RET_EMPTY,
      OP_CONFLICT: begin
        err_set = 1'b1;
      end

      default: begin
        pc_next = pc;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge, and the MBR and
    // MAR copies depend on that.
    if (!rst) begin
      pc          <= '0;
      sp          <= '0;
      wr_ptr      <= '0;
      stack_err   <= 1'b0;
      data_to_mbr <= '0;
      data_to_mar <= '0;
    end else begin
      pc     <= pc_next;
      sp     <= sp_next;
      wr_ptr <= wr_ptr_next;
      if (err_set) begin
        stack_err <= 1'b1;
      end
      // The copies take the PC from before this edge's update.
      if (do_to_mbr) begin
        data_to_mbr <= pc;
      end
      if (do_to_mar) begin
        data_to_mar <= pc;
      end
    end
  end

  // NOTE: the stack storage is not reset. An entry is only read after a push
  // has written it (sp guards every read), so clearing it would add reset
  // fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[wr_ptr] <= ret_addr;
    end
  end

  assign pc_out = pc;

endmodule
